mips_cpu_mem_ctrl: RTL and testbench
====================================

Name: mips_cpu_mem_ctrl

Overview:
Memory-bus initiator for the multicycle MIPS core. It drives an Avalon-style bus with read/write/waitrequest for instruction fetches and load/store data accesses. Fetched words are delivered with a one-cycle IR write strobe to the instruction register, which is the block downstream of this one. Load data is returned lane-extracted and sign- or zero-extended, and store data is lane-shifted with byteenables.

Parameters:
TIMEOUT_CYCLES, 256, waitrequest cycles tolerated before abort (used only when MEM_CTRL_TIMEOUT_EN is defined)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_req  input  1  request instruction fetch at pc; held until done
pc  input  32  fetch byte address
data_req  input  1  request data access; held until done
data_we  input  1  1 = store, 0 = load
data_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as fault)
data_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend
data_addr  input  32  data byte address
data_wdata  input  32  store data, right-justified
address  output  32  bus word address; bits [1:0] always 0
read  output  1  bus read strobe
write  output  1  bus write strobe
byteenable  output  4  bus lane enables, lane n = bits [8n+7:8n], little-endian
writedata  output  32  lane-shifted store data
waitrequest  input  1  bus stall
readdata  input  32  bus read data
busy  output  1  high in any state except IDLE
done  output  1  one-cycle completion pulse
fault  output  1  valid with done: misaligned, reserved size, or timeout
ir_write  output  1  one-cycle pulse with done for a fetch; connects to the instruction register's IRWrite
mem_word  output  32  raw fetched word, stable from done until the next fetch completes
load_data  output  32  extended load result, stable from done until the next load completes

Behaviour:
- States: IDLE, FETCH, DATA, RESP.
- IDLE: requests are sampled only in this state. fetch_req has priority over data_req. The alignment check is made on entry:
  - fetch or word: addr[1:0] must be 00.
  - half: addr[0] must be 0.
  - size 11 is a fault.
  - On a fault: no bus cycle, go to RESP with fault=1.
- FETCH: read=1, address={pc[31:2],2'b00}, byteenable=1111. Strobes and address are held while waitrequest=1. On the first cycle with waitrequest=0: latch readdata into mem_word, go to RESP.
- DATA load: read=1, byteenable by size/lane:
  - byte: one-hot on addr[1:0].
  - half: 0011 or 1100.
  - word: 1111.
  - On completion: extract the lane, extend per data_signed, latch into load_data.
- DATA store: write=1, writedata=data_wdata shifted left by 8*addr[1:0]; unused lanes are don't-care, driven 0. Completion is on waitrequest=0.
- RESP (one cycle): done=1, fault as recorded, ir_write=1 only if the access was a fault-free fetch. Then back to IDLE. Minimum latency from request to done is 2 cycles (request cycle, bus cycle with waitrequest=0, done next cycle).
- read and write are never high together. Both are 0 outside FETCH/DATA.
- The requester must drop a request in the done cycle. A request still high in IDLE after RESP starts a new access.
- Simultaneous fetch_req and data_req: fetch is served first; data is served after the fetch's done if data_req is still held.
- Reset (including mid-transaction): next edge gives state=IDLE, and read, write, done, fault, ir_write, busy, byteenable, address, writedata, mem_word and load_data are all 0. The bus transaction is abandoned.

Optional Feature:
MEM_CTRL_TIMEOUT_EN
- Defined: a counter of consecutive waitrequest=1 cycles in FETCH/DATA. On reaching TIMEOUT_CYCLES, drop read/write and go to RESP with fault=1 and ir_write=0. mem_word and load_data are not updated.
- Undefined: no counter, and the block waits on waitrequest indefinitely.

Test Plan:
1. fetch_req, pc=0xBFC00004, waitrequest=0, readdata=0x8C220008 -> address=0xBFC00004, read=1 for one cycle; next cycle done=1, ir_write=1, mem_word=0x8C220008, fault=0.
2. Signed byte load at addr 0x1003, readdata=0x80FFFFFF, waitrequest high 3 cycles -> byteenable=1000, read held 4 cycles, load_data=0xFFFFFF80; repeat with data_signed=0 -> 0x00000080.
3. Half store, addr 0x2002, data_wdata=0x0000ABCD -> write=1, byteenable=1100, writedata[31:16]=0xABCD, done next cycle after waitrequest=0.
4. Word load addr 0x3001, then fetch pc=0x4002 -> no read/write asserted, done=1 with fault=1 in each case, ir_write=0.
5. fetch_req and data_req in the same cycle -> fetch completes (ir_write=1) before any data bus strobe; reset during a stalled read -> read=0 and busy=0 after the next edge.
6. With MEM_CTRL_TIMEOUT_EN, waitrequest stuck at 1 -> after 256 stall cycles read=0, done=1, fault=1; without the macro, read is still 1 after 1000 cycles.

Source files
------------

// File: rtl/mips_cpu_mem_ctrl.sv
// mips_cpu_mem_ctrl: memory-bus initiator for the multicycle MIPS core.
// Serves instruction fetches and load/store data accesses over an
// Avalon-style read/write/waitrequest bus. Fetched words go to the
// instruction register with a one-cycle ir_write strobe; loads are
// lane-extracted and sign/zero-extended; stores are lane-shifted with
// byteenables.
//
// Optional feature: define MEM_CTRL_TIMEOUT_EN to abort a bus access after
// TIMEOUT_CYCLES consecutive waitrequest cycles (completes with fault=1).
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   fetch_req, pc      instruction fetch request and byte address
//   data_req, data_we, data_size, data_signed, data_addr, data_wdata
//                      data access request and attributes
//   address, read, write, byteenable, writedata, waitrequest, readdata
//                      Avalon-style bus
//   busy, done, fault  status; done/fault pulse for one cycle
//   ir_write           fetch completion strobe to the instruction register
//   mem_word           last fetched word
//   load_data          last extended load result
module mips_cpu_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] pc,
   input  logic        data_req,
   input  logic        data_we,
   input  logic [1:0]  data_size,
   input  logic        data_signed,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic        ir_write,
   output logic [31:0] mem_word,
   output logic [31:0] load_data
);

   localparam int unsigned DW  = 32;
   localparam int unsigned BEW = 4;

   typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

   // Parameter sanity check at elaboration.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t          state_q, state_d;
   logic [DW-1:0]   address_q, address_d;
   logic            read_q, read_d;
   logic            write_q, write_d;
   logic [BEW-1:0]  byteenable_q, byteenable_d;
   logic [DW-1:0]   writedata_q, writedata_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            fault_q, fault_d;
   logic            ir_write_q, ir_write_d;
   logic [DW-1:0]   mem_word_q, mem_word_d;
   logic [DW-1:0]   load_data_q, load_data_d;
   // Attributes of the data access in flight
   logic [1:0]      lane_q, lane_d;
   logic [1:0]      size_q, size_d;
   logic            signed_q, signed_d;
   logic            we_q, we_d;

`ifdef MEM_CTRL_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_c;
   assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Lane enables for a data access of the given size at the given byte lane.
   function automatic logic [BEW-1:0] lane_mask(input logic [1:0] size,
                                                input logic [1:0] lane);
      logic [BEW-1:0] m;
      case (size)
         2'b00:   m = BEW'(4'b0001 << lane);
         2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Store data shifted into its lanes, unused lanes forced to 0.
   logic [BEW-1:0] req_be_c;
   logic [DW-1:0]  req_bitmask_c;
   logic [DW-1:0]  store_data_c;
   logic           data_misalign_c;

   always_comb begin
      req_be_c = lane_mask(data_size, data_addr[1:0]);
      for (int i = 0; i < int'(BEW); i++) begin
         req_bitmask_c[8*i +: 8] = {8{req_be_c[i]}};
      end
      store_data_c    = (data_wdata << {data_addr[1:0], 3'b000}) & req_bitmask_c;
      data_misalign_c = (data_size == 2'b11)
                     || (data_size == 2'b10 && data_addr[1:0] != 2'b00)
                     || (data_size == 2'b01 && data_addr[0]);
   end

   // Load lane extraction and extension using the recorded access attributes.
   logic [DW-1:0] rd_shift_c;
   logic [DW-1:0] load_ext_c;

   always_comb begin
      rd_shift_c = readdata >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   load_ext_c = {{24{signed_q & rd_shift_c[7]}},  rd_shift_c[7:0]};
         2'b01:   load_ext_c = {{16{signed_q & rd_shift_c[15]}}, rd_shift_c[15:0]};
         default: load_ext_c = readdata;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      address_d    = address_q;
      read_d       = read_q;
      write_d      = write_q;
      byteenable_d = byteenable_q;
      writedata_d  = writedata_q;
      done_d       = 1'b0;
      fault_d      = 1'b0;
      ir_write_d   = 1'b0;
      mem_word_d   = mem_word_q;
      load_data_d  = load_data_q;
      lane_d       = lane_q;
      size_d       = size_q;
      signed_d     = signed_q;
      we_d         = we_q;
`ifdef MEM_CTRL_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif

      case (state_q)
         IDLE: begin
`ifdef MEM_CTRL_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (fetch_req) begin
               if (pc[1:0] != 2'b00) begin
                  state_d = RESP;
                  done_d  = 1'b1;
                  fault_d = 1'b1;
               end else begin
                  state_d      = FETCH;
                  read_d       = 1'b1;
                  address_d    = {pc[31:2], 2'b00};
                  byteenable_d = 4'b1111;
               end
            end else if (data_req) begin
               if (data_misalign_c) begin
                  state_d = RESP;
                  done_d  = 1'b1;
                  fault_d = 1'b1;
               end else begin
                  state_d      = DATA;
                  address_d    = {data_addr[31:2], 2'b00};
                  byteenable_d = req_be_c;
                  lane_d       = data_addr[1:0];
                  size_d       = data_size;
                  signed_d     = data_signed;
                  we_d         = data_we;
                  read_d       = ~data_we;
                  write_d      = data_we;
                  if (data_we) begin
                     writedata_d = store_data_c;
                  end
               end
            end
         end

         FETCH: begin
            if (!waitrequest) begin
               state_d    = RESP;
               read_d     = 1'b0;
               done_d     = 1'b1;
               ir_write_d = 1'b1;
               mem_word_d = readdata;
            end
`ifdef MEM_CTRL_TIMEOUT_EN
            else if (timeout_c) begin
               state_d = RESP;
               read_d  = 1'b0;
               done_d  = 1'b1;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end

         DATA: begin
            if (!waitrequest) begin
               state_d = RESP;
               read_d  = 1'b0;
               write_d = 1'b0;
               done_d  = 1'b1;
               if (!we_q) begin
                  load_data_d = load_ext_c;
               end
            end
`ifdef MEM_CTRL_TIMEOUT_EN
            else if (timeout_c) begin
               state_d = RESP;
               read_d  = 1'b0;
               write_d = 1'b0;
               done_d  = 1'b1;
               fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         address_q    <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         byteenable_q <= '0;
         writedata_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         fault_q      <= 1'b0;
         ir_write_q   <= 1'b0;
         mem_word_q   <= '0;
         load_data_q  <= '0;
         lane_q       <= '0;
         size_q       <= '0;
         signed_q     <= 1'b0;
         we_q         <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         address_q    <= address_d;
         read_q       <= read_d;
         write_q      <= write_d;
         byteenable_q <= byteenable_d;
         writedata_q  <= writedata_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         fault_q      <= fault_d;
         ir_write_q   <= ir_write_d;
         mem_word_q   <= mem_word_d;
         load_data_q  <= load_data_d;
         lane_q       <= lane_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         we_q         <= we_d;
`ifdef MEM_CTRL_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign address    = address_q;
   assign read       = read_q;
   assign write      = write_q;
   assign byteenable = byteenable_q;
   assign writedata  = writedata_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign ir_write   = ir_write_q;
   assign mem_word   = mem_word_q;
   assign load_data  = load_data_q;

endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// Directed self-checking bench for mips_cpu_mem_ctrl.
module tb_mips_cpu_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] pc;
   logic        data_req;
   logic        data_we;
   logic [1:0]  data_size;
   logic        data_signed;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        busy;
   logic        done;
   logic        fault;
   logic        ir_write;
   logic [31:0] mem_word;
   logic [31:0] load_data;

   int n_cmp = 0;
   int n_err = 0;

   mips_cpu_mem_ctrl dut (
      .clk(clk), .reset(reset),
      .fetch_req(fetch_req), .pc(pc),
      .data_req(data_req), .data_we(data_we), .data_size(data_size),
      .data_signed(data_signed), .data_addr(data_addr), .data_wdata(data_wdata),
      .address(address), .read(read), .write(write), .byteenable(byteenable),
      .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
      .busy(busy), .done(done), .fault(fault), .ir_write(ir_write),
      .mem_word(mem_word), .load_data(load_data)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; fetch_req = 1'b0; pc = '0; data_req = 1'b0; data_we = 1'b0;
      data_size = 2'b00; data_signed = 1'b0; data_addr = '0; data_wdata = '0;
      waitrequest = 1'b0; readdata = '0;
      tick(); tick();
      n_cmp++; if (read !== 1'b0 || write !== 1'b0) begin n_err++; $display("FAIL reset_strobes read=%b write=%b want 0 0", read, write); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || ir_write !== 1'b0) begin n_err++; $display("FAIL reset_status busy=%b done=%b fault=%b ir_write=%b want 0", busy, done, fault, ir_write); end
      n_cmp++; if (address !== 32'h0 || byteenable !== 4'h0 || writedata !== 32'h0) begin n_err++; $display("FAIL reset_bus addr=%h be=%b wd=%h want 0", address, byteenable, writedata); end
      n_cmp++; if (mem_word !== 32'h0 || load_data !== 32'h0) begin n_err++; $display("FAIL reset_data mem_word=%h load_data=%h want 0", mem_word, load_data); end
      reset = 1'b0;
   endtask

   task automatic test_fetch();
      fetch_req = 1'b1; pc = 32'hBFC0_0004; waitrequest = 1'b0; readdata = 32'h8C22_0008;
      tick();
      n_cmp++; if (read !== 1'b1 || write !== 1'b0 || address !== 32'hBFC0_0004 || byteenable !== 4'b1111) begin n_err++; $display("FAIL fetch_bus read=%b write=%b addr=%h be=%b want 1 0 bfc00004 1111", read, write, address, byteenable); end
      n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL fetch_busy done=%b busy=%b want 0 1", done, busy); end
      tick();
      fetch_req = 1'b0;
      n_cmp++; if (done !== 1'b1 || ir_write !== 1'b1 || fault !== 1'b0 || read !== 1'b0) begin n_err++; $display("FAIL fetch_done done=%b ir=%b fault=%b read=%b want 1 1 0 0", done, ir_write, fault, read); end
      n_cmp++; if (mem_word !== 32'h8C22_0008) begin n_err++; $display("FAIL fetch_word got %h want 8c220008", mem_word); end
      readdata = 32'h1111_1111;
      tick();
      n_cmp++; if (done !== 1'b0 || ir_write !== 1'b0 || busy !== 1'b0 || mem_word !== 32'h8C22_0008) begin n_err++; $display("FAIL fetch_idle done=%b ir=%b busy=%b mem_word=%h want 0 0 0 8c220008", done, ir_write, busy, mem_word); end
   endtask

   task automatic test_byte_load();
      int rd_cycles;
      // Signed byte load with three stall cycles
      data_req = 1'b1; data_we = 1'b0; data_size = 2'b00; data_signed = 1'b1;
      data_addr = 32'h0000_1003; readdata = 32'h80FF_FFFF; waitrequest = 1'b1;
      tick();
      n_cmp++; if (byteenable !== 4'b1000 || address !== 32'h0000_1000 || write !== 1'b0) begin n_err++; $display("FAIL lb_bus be=%b addr=%h write=%b want 1000 00001000 0", byteenable, address, write); end
      rd_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         if (read === 1'b1) rd_cycles++;
         tick();
      end
      waitrequest = 1'b0;
      if (read === 1'b1) rd_cycles++;
      tick();
      data_req = 1'b0;
      n_cmp++; if (rd_cycles !== 4) begin n_err++; $display("FAIL lb_read_len got %0d want 4", rd_cycles); end
      n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || ir_write !== 1'b0 || read !== 1'b0) begin n_err++; $display("FAIL lb_done done=%b fault=%b ir=%b read=%b want 1 0 0 0", done, fault, ir_write, read); end
      n_cmp++; if (load_data !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_signed got %h want ffffff80", load_data); end
      tick();
      // Same access, zero-extended
      data_req = 1'b1; data_signed = 1'b0;
      tick();
      tick();
      data_req = 1'b0;
      n_cmp++; if (done !== 1'b1 || load_data !== 32'h0000_0080) begin n_err++; $display("FAIL lbu done=%b got %h want 1 00000080", done, load_data); end
      tick();
      // Signed half load from upper lane
      data_req = 1'b1; data_size = 2'b01; data_signed = 1'b1; data_addr = 32'h0000_1002;
      readdata = 32'h9234_5678;
      tick();
      n_cmp++; if (byteenable !== 4'b1100) begin n_err++; $display("FAIL lh_be got %b want 1100", byteenable); end
      tick();
      data_req = 1'b0;
      n_cmp++; if (load_data !== 32'hFFFF_9234) begin n_err++; $display("FAIL lh_signed got %h want ffff9234", load_data); end
      tick();
   endtask

   task automatic test_store();
      data_req = 1'b1; data_we = 1'b1; data_size = 2'b01; data_signed = 1'b0;
      data_addr = 32'h0000_2002; data_wdata = 32'h0000_ABCD; waitrequest = 1'b0;
      tick();
      n_cmp++; if (write !== 1'b1 || read !== 1'b0 || byteenable !== 4'b1100 || address !== 32'h0000_2000) begin n_err++; $display("FAIL sh_bus write=%b read=%b be=%b addr=%h want 1 0 1100 00002000", write, read, byteenable, address); end
      n_cmp++; if (writedata !== 32'hABCD_0000) begin n_err++; $display("FAIL sh_wdata got %h want abcd0000", writedata); end
      tick();
      data_req = 1'b0;
      n_cmp++; if (done !== 1'b1 || fault !== 1'b0 || write !== 1'b0 || ir_write !== 1'b0) begin n_err++; $display("FAIL sh_done done=%b fault=%b write=%b ir=%b want 1 0 0 0", done, fault, write, ir_write); end
      n_cmp++; if (load_data !== 32'hFFFF_9234) begin n_err++; $display("FAIL sh_load_hold got %h want ffff9234", load_data); end
      tick();
      // Byte store: upper bits of data_wdata must not leak into unused lanes
      data_req = 1'b1; data_size = 2'b00; data_addr = 32'h0000_2001; data_wdata = 32'h1234_56EF;
      tick();
      n_cmp++; if (byteenable !== 4'b0010 || writedata !== 32'h0000_EF00) begin n_err++; $display("FAIL sb_lane be=%b wd=%h want 0010 0000ef00", byteenable, writedata); end
      tick();
      data_req = 1'b0;
      tick();
      data_we = 1'b0;
   endtask

   task automatic test_faults();
      // Misaligned word load
      data_req = 1'b1; data_we = 1'b0; data_size = 2'b10; data_addr = 32'h0000_3001;
      tick();
      n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || ir_write !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin n_err++; $display("FAIL lw_misalign done=%b fault=%b ir=%b read=%b write=%b want 1 1 0 0 0", done, fault, ir_write, read, write); end
      data_req = 1'b0;
      tick();
      // Misaligned fetch
      fetch_req = 1'b1; pc = 32'h0000_4002;
      tick();
      n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || ir_write !== 1'b0 || read !== 1'b0) begin n_err++; $display("FAIL fetch_misalign done=%b fault=%b ir=%b read=%b want 1 1 0 0", done, fault, ir_write, read); end
      n_cmp++; if (mem_word !== 32'h8C22_0008) begin n_err++; $display("FAIL fetch_misalign_word got %h want 8c220008", mem_word); end
      fetch_req = 1'b0;
      tick();
      // Reserved size at an aligned address
      data_req = 1'b1; data_we = 1'b1; data_size = 2'b11; data_addr = 32'h0000_3000;
      tick();
      n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || write !== 1'b0) begin n_err++; $display("FAIL size11 done=%b fault=%b write=%b want 1 1 0", done, fault, write); end
      data_req = 1'b0; data_we = 1'b0;
      tick();
      // Odd half address
      data_req = 1'b1; data_size = 2'b01; data_addr = 32'h0000_3003;
      tick();
      n_cmp++; if (done !== 1'b1 || fault !== 1'b1 || read !== 1'b0) begin n_err++; $display("FAIL half_odd done=%b fault=%b read=%b want 1 1 0", done, fault, read); end
      data_req = 1'b0;
      tick();
      n_cmp++; if (done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL fault_clear done=%b fault=%b busy=%b want 0 0 0", done, fault, busy); end
   endtask

   task automatic test_back_to_back();
      fetch_req = 1'b1; pc = 32'h0000_0100;
      data_req = 1'b1; data_we = 1'b0; data_size = 2'b10; data_signed = 1'b0; data_addr = 32'h0000_0200;
      readdata = 32'hDEAD_BEEF; waitrequest = 1'b0;
      tick();
      n_cmp++; if (read !== 1'b1 || address !== 32'h0000_0100 || write !== 1'b0) begin n_err++; $display("FAIL b2b_fetch_first read=%b addr=%h write=%b want 1 00000100 0", read, address, write); end
      tick();
      fetch_req = 1'b0;
      n_cmp++; if (done !== 1'b1 || ir_write !== 1'b1 || mem_word !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_fetch_done done=%b ir=%b word=%h want 1 1 deadbeef", done, ir_write, mem_word); end
      tick();
      n_cmp++; if (read !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle read=%b busy=%b want 0 0", read, busy); end
      tick();
      n_cmp++; if (read !== 1'b1 || address !== 32'h0000_0200 || byteenable !== 4'b1111) begin n_err++; $display("FAIL b2b_data read=%b addr=%h be=%b want 1 00000200 1111", read, address, byteenable); end
      tick();
      data_req = 1'b0;
      n_cmp++; if (done !== 1'b1 || ir_write !== 1'b0 || load_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_data_done done=%b ir=%b load=%h want 1 0 deadbeef", done, ir_write, load_data); end
      tick();
      // Reset during a stalled fetch
      fetch_req = 1'b1; pc = 32'h0000_0500; waitrequest = 1'b1;
      tick();
      tick();
      n_cmp++; if (read !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL stall_pre_reset read=%b busy=%b want 1 1", read, busy); end
      reset = 1'b1; fetch_req = 1'b0;
      tick();
      reset = 1'b0;
      n_cmp++; if (read !== 1'b0 || busy !== 1'b0 || address !== 32'h0 || byteenable !== 4'h0) begin n_err++; $display("FAIL reset_mid read=%b busy=%b addr=%h be=%b want 0 0 0 0", read, busy, address, byteenable); end
      n_cmp++; if (mem_word !== 32'h0 || load_data !== 32'h0 || done !== 1'b0) begin n_err++; $display("FAIL reset_mid_data word=%h load=%h done=%b want 0 0 0", mem_word, load_data, done); end
   endtask

   task automatic test_timeout();
      int rd_cycles;
      bit seen_done;
      fetch_req = 1'b1; pc = 32'h0000_0600; waitrequest = 1'b1; readdata = 32'h5555_AAAA;
      tick();
      fetch_req = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
      rd_cycles = 0; seen_done = 1'b0;
      for (int i = 0; i < 2000 && !seen_done; i++) begin
         if (done === 1'b1) seen_done = 1'b1;
         else begin
            if (read === 1'b1) rd_cycles++;
            tick();
         end
      end
      n_cmp++; if (!seen_done) begin n_err++; $display("FAIL timeout_done no done within 2000 cycles, want done"); end
      n_cmp++; if (rd_cycles !== 256) begin n_err++; $display("FAIL timeout_len read cycles %0d want 256", rd_cycles); end
      n_cmp++; if (read !== 1'b0 || fault !== 1'b1 || ir_write !== 1'b0) begin n_err++; $display("FAIL timeout_resp read=%b fault=%b ir=%b want 0 1 0", read, fault, ir_write); end
      n_cmp++; if (mem_word !== 32'h0) begin n_err++; $display("FAIL timeout_word got %h want 0", mem_word); end
`else
      rd_cycles = 0; seen_done = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (done === 1'b1) seen_done = 1'b1;
         if (read === 1'b1) rd_cycles++;
         tick();
      end
      n_cmp++; if (read !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL no_timeout_read read=%b busy=%b want 1 1", read, busy); end
      n_cmp++; if (seen_done || rd_cycles !== 1000) begin n_err++; $display("FAIL no_timeout_wait done_seen=%0d read cycles %0d want 0 1000", seen_done, rd_cycles); end
`endif
      reset = 1'b1; waitrequest = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_byte_load();
      test_store();
      test_faults();
      test_back_to_back();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
